// File: rtl/ddr3_arb_pkg.sv
// Shared constants for the DDR3 command arbiter: MIG command codes and the one-hot grant states.
package ddr3_arb_pkg;

    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    localparam int IDLE_IDX   = 0;
    localparam int WR_GNT_IDX = 1;
    localparam int RD_GNT_IDX = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'b001,
        WR_GNT = 3'b010,
        RD_GNT = 3'b100
    } arb_state_e;

endpackage

// File: rtl/ddr3_arb_stats.sv
// Accepted-command and turnaround counters for the DDR3 command arbiter.
// Only present when DDR3_ARB_STATS_EN is defined; all counters wrap and clear on reset.
`ifdef DDR3_ARB_STATS_EN
module ddr3_arb_stats (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr_accept,
    input  logic        rd_accept,
    input  logic        turn,
    output logic [31:0] arb_wr_cmds,
    output logic [31:0] arb_rd_cmds,
    output logic [15:0] arb_turns
);

    logic [31:0] wr_cmds_q, wr_cmds_d;
    logic [31:0] rd_cmds_q, rd_cmds_d;
    logic [15:0] turns_q,   turns_d;

    always_comb begin
        wr_cmds_d = wr_cmds_q + (wr_accept ? 32'd1 : 32'd0);
        rd_cmds_d = rd_cmds_q + (rd_accept ? 32'd1 : 32'd0);
        turns_d   = turns_q   + (turn      ? 16'd1 : 16'd0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_cmds_q <= '0;
            rd_cmds_q <= '0;
            turns_q   <= '0;
        end else begin
            wr_cmds_q <= wr_cmds_d;
            rd_cmds_q <= rd_cmds_d;
            turns_q   <= turns_d;
        end
    end

    assign arb_wr_cmds = wr_cmds_q;
    assign arb_rd_cmds = rd_cmds_q;
    assign arb_turns   = turns_q;

endmodule
`endif

// File: rtl/ddr3_cmd_arbiter.sv
// Shares the MIG command port between the write and read controllers, granting runs of commands.
// Optional statistics counters are built when DDR3_ARB_STATS_EN is defined.
module ddr3_cmd_arbiter
    import ddr3_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = 26,
    parameter int unsigned MAX_GRANT = 16,
    parameter int unsigned CNT_W     = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_app_en,
    input  logic [ADDR_W-1:0] wr_addr,
    output logic              wr_app_rdy,
    input  logic              rd_app_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_app_rdy,
    output logic              app_en,
    output logic [2:0]        app_cmd,
    output logic [ADDR_W-1:0] app_addr,
    input  logic              app_rdy,
    output logic              arb_wr_gnt,
    output logic              arb_rd_gnt
`ifdef DDR3_ARB_STATS_EN
    ,
    output logic [31:0]       arb_wr_cmds,
    output logic [31:0]       arb_rd_cmds,
    output logic [15:0]       arb_turns
`endif
);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] grant_cnt_q, grant_cnt_d;
    logic             wr_own, rd_own;
    logic             owner_en, other_en, accept;
    logic [CNT_W:0]   cnt_inc;
    logic             quota_full, quota_hit, yield;

    assign wr_own   = state_q[WR_GNT_IDX];
    assign rd_own   = state_q[RD_GNT_IDX];
    assign owner_en = (wr_own && wr_app_en) || (rd_own && rd_app_en);
    assign other_en = (wr_own && rd_app_en) || (rd_own && wr_app_en);
    assign accept   = owner_en && app_rdy;

    // A stalled command (owner_en && !app_rdy) never yields, so app_en/addr stay stable for the MIG.
    assign cnt_inc    = {1'b0, grant_cnt_q} + (CNT_W+1)'(1);
    assign quota_full = (grant_cnt_q == CNT_W'(MAX_GRANT));
    assign quota_hit  = accept && ((cnt_inc >= (CNT_W+1)'(MAX_GRANT)) || quota_full);
    assign yield      = other_en && (!owner_en || quota_hit);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            grant_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_cnt_q <= grant_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_cnt_d = grant_cnt_q;
        case (state_q)
            IDLE: begin
                if (wr_app_en)      state_d = WR_GNT;
                else if (rd_app_en) state_d = RD_GNT;
            end
            WR_GNT:  if (yield) state_d = RD_GNT;
            RD_GNT:  if (yield) state_d = WR_GNT;
            default: state_d = IDLE;
        endcase
        if (state_d != state_q)
            grant_cnt_d = '0;
        else if (accept && !quota_full)
            grant_cnt_d = grant_cnt_q + CNT_W'(1);
    end

    always_comb begin
        app_en     = owner_en;
        app_cmd    = rd_own ? CMD_RD : CMD_WR;
        app_addr   = '0;
        if (wr_own) app_addr = wr_addr;
        if (rd_own) app_addr = rd_addr;
        wr_app_rdy = wr_own && app_rdy;
        rd_app_rdy = rd_own && app_rdy;
        arb_wr_gnt = wr_own;
        arb_rd_gnt = rd_own;
    end

`ifdef DDR3_ARB_STATS_EN
    logic turn;
    assign turn = (wr_own && state_d[RD_GNT_IDX]) || (rd_own && state_d[WR_GNT_IDX]);

    ddr3_arb_stats u_stats (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_accept   (accept && wr_own),
        .rd_accept   (accept && rd_own),
        .turn        (turn),
        .arb_wr_cmds (arb_wr_cmds),
        .arb_rd_cmds (arb_rd_cmds),
        .arb_turns   (arb_turns)
    );
`endif

endmodule

// File: tb/tb_ddr3_cmd_arbiter.sv
// Self-checking bench for ddr3_cmd_arbiter: directed scenarios plus randomized traffic
// compared every cycle against an owner/run-length model of the arbitration rules.
module tb_ddr3_cmd_arbiter;

    localparam int ADDR_W    = 26;
    localparam int MAX_GRANT = 16;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              wr_app_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic              wr_app_rdy;
    logic              rd_app_en = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic              rd_app_rdy;
    logic              app_en;
    logic [2:0]        app_cmd;
    logic [ADDR_W-1:0] app_addr;
    logic              app_rdy = 1'b0;
    logic              arb_wr_gnt;
    logic              arb_rd_gnt;

    int compared   = 0;
    int mismatched = 0;

    // Model: who owns the port (0 none, 1 write, 2 read) and how many commands this grant accepted.
    int   m_owner = 0;
    int   m_run   = 0;
    logic exp_en;

    logic              last_en, last_wrdy, last_rrdy, last_wgnt, last_rgnt;
    logic [2:0]        last_cmd;
    logic [ADDR_W-1:0] last_addr;

    ddr3_cmd_arbiter #(.ADDR_W(ADDR_W), .MAX_GRANT(MAX_GRANT), .CNT_W(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_app_en  (wr_app_en),
        .wr_addr    (wr_addr),
        .wr_app_rdy (wr_app_rdy),
        .rd_app_en  (rd_app_en),
        .rd_addr    (rd_addr),
        .rd_app_rdy (rd_app_rdy),
        .app_en     (app_en),
        .app_cmd    (app_cmd),
        .app_addr   (app_addr),
        .app_rdy    (app_rdy),
        .arb_wr_gnt (arb_wr_gnt),
        .arb_rd_gnt (arb_rd_gnt)
    );

    always #5 clk = ~clk;

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [ADDR_W-1:0] wa,
                                 input logic re, input logic [ADDR_W-1:0] ra, input logic ar);
        wr_app_en = we;
        wr_addr   = wa;
        rd_app_en = re;
        rd_addr   = ra;
        app_rdy   = ar;
    endtask

    // Samples the DUT and checks every output against what the current owner implies.
    task automatic checkOutput();
        logic [ADDR_W-1:0] exp_addr;
        exp_en   = (m_owner == 1) ? wr_app_en : (m_owner == 2) ? rd_app_en : 1'b0;
        exp_addr = (m_owner == 1) ? wr_addr : (m_owner == 2) ? rd_addr : '0;
        last_en   = app_en;
        last_cmd  = app_cmd;
        last_addr = app_addr;
        last_wrdy = wr_app_rdy;
        last_rrdy = rd_app_rdy;
        last_wgnt = arb_wr_gnt;
        last_rgnt = arb_rd_gnt;
        compare("app_en",     32'(app_en),     32'(exp_en));
        compare("app_cmd",    32'(app_cmd),    (m_owner == 2) ? 32'd1 : 32'd0);
        compare("app_addr",   32'(app_addr),   32'(exp_addr));
        compare("wr_app_rdy", 32'(wr_app_rdy), 32'((m_owner == 1) && app_rdy));
        compare("rd_app_rdy", 32'(rd_app_rdy), 32'((m_owner == 2) && app_rdy));
        compare("arb_wr_gnt", 32'(arb_wr_gnt), 32'(m_owner == 1));
        compare("arb_rd_gnt", 32'(arb_rd_gnt), 32'(m_owner == 2));
        compare("one_grant",  32'(arb_wr_gnt && arb_rd_gnt), 32'd0);
    endtask

    task automatic modelStep();
        logic accepted, other;
        accepted = exp_en && app_rdy;
        if (m_owner == 0) begin
            if (wr_app_en)      m_owner = 1;
            else if (rd_app_en) m_owner = 2;
            m_run = 0;
        end else begin
            other = (m_owner == 1) ? rd_app_en : wr_app_en;
            if (other && (!exp_en || (accepted && m_run + 1 >= MAX_GRANT))) begin
                m_owner = 3 - m_owner;
                m_run   = 0;
            end else if (accepted) begin
                m_run++;
            end
        end
    endtask

    task automatic runCycle(input logic we, input logic [ADDR_W-1:0] wa,
                            input logic re, input logic [ADDR_W-1:0] ra, input logic ar);
        applyStimulus(we, wa, re, ra, ar);
        @(negedge clk);
        checkOutput();
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
        reset_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        m_owner = 0;
        m_run   = 0;
    endtask

    // Drops reset between clock edges and expects every output to fall at once.
    task automatic midCycleReset(input string tag);
        #2;
        reset_n = 1'b0;
        #1;
        compare({tag, "_app_en"},  32'(app_en),     32'd0);
        compare({tag, "_wr_gnt"},  32'(arb_wr_gnt), 32'd0);
        compare({tag, "_rd_gnt"},  32'(arb_rd_gnt), 32'd0);
        compare({tag, "_wr_rdy"},  32'(wr_app_rdy), 32'd0);
        compare({tag, "_app_addr"}, 32'(app_addr),  32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        m_owner = 0;
        m_run   = 0;
    endtask

    initial begin
        int runs[$];
        int cur_side, cur_len;
        int p_we, p_re, p_rdy;

        $display("[TB] start");
        doReset();

        // Scenario 1: one cycle of grant latency, then the write goes straight through.
        runCycle(1'b1, 26'h0000008, 1'b0, '0, 1'b1);
        compare("s1_idle_app_en", 32'(last_en), 32'd0);
        compare("s1_idle_wr_gnt", 32'(last_wgnt), 32'd0);
        runCycle(1'b1, 26'h0000008, 1'b0, '0, 1'b1);
        compare("s1_wr_gnt",   32'(last_wgnt), 32'd1);
        compare("s1_app_en",   32'(last_en),   32'd1);
        compare("s1_app_cmd",  32'(last_cmd),  32'd0);
        compare("s1_app_addr", 32'(last_addr), 32'h0000008);
        compare("s1_wr_rdy",   32'(last_wrdy), 32'd1);

        // Scenario 2: both sides saturating, expect alternating runs of MAX_GRANT.
        doReset();
        cur_side = 0;
        cur_len  = 0;
        for (int i = 0; i < 64; i++) begin
            runCycle(1'b1, 26'($urandom()), 1'b1, 26'($urandom()), 1'b1);
            if (last_wrdy || last_rrdy) begin
                if ((last_wrdy ? 1 : 2) != cur_side) begin
                    if (cur_side != 0) runs.push_back(cur_len);
                    cur_side = last_wrdy ? 1 : 2;
                    cur_len  = 0;
                end
                cur_len++;
            end
        end
        runs.push_back(cur_len);
        compare("s2_run_count", 32'(runs.size()), 32'd4);
        compare("s2_run0_wr",   32'(runs[0]), 32'd16);
        compare("s2_run1_rd",   32'(runs[1]), 32'd16);
        compare("s2_run2_wr",   32'(runs[2]), 32'd16);
        compare("s2_run3_rd",   32'(runs[3]), 32'd15);
        compare("s2_last_side", 32'(cur_side), 32'd2);

        // Scenario 3: a stalled write keeps the grant and its address.
        doReset();
        runCycle(1'b1, 26'h0000123, 1'b0, '0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            runCycle(1'b1, 26'h0000123, 1'b1, 26'h0000055, 1'b0);
            compare("s3_held_gnt",  32'(last_wgnt), 32'd1);
            compare("s3_held_addr", 32'(last_addr), 32'h0000123);
        end
        runCycle(1'b1, 26'h0000123, 1'b1, 26'h0000055, 1'b1);
        compare("s3_accept_rdy",  32'(last_wrdy), 32'd1);
        compare("s3_accept_addr", 32'(last_addr), 32'h0000123);
        runCycle(1'b0, '0, 1'b1, 26'h0000055, 1'b1);
        compare("s3_yield_edge_gnt", 32'(last_wgnt), 32'd1);
        runCycle(1'b0, '0, 1'b1, 26'h0000055, 1'b1);
        compare("s3_rd_gnt", 32'(last_rgnt), 32'd1);
        compare("s3_rd_rdy", 32'(last_rrdy), 32'd1);

        // Scenario 4: write parks the grant, then the read takes over.
        doReset();
        runCycle(1'b1, 26'h0000010, 1'b0, '0, 1'b1);
        for (int i = 0; i < 3; i++) runCycle(1'b1, 26'(16 + i), 1'b0, '0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            runCycle(1'b0, '0, 1'b0, '0, 1'b1);
            compare("s4_parked_gnt", 32'(last_wgnt), 32'd1);
        end
        runCycle(1'b0, '0, 1'b1, 26'h0000077, 1'b1);
        compare("s4_switch_edge_rrdy", 32'(last_rrdy), 32'd0);
        runCycle(1'b0, '0, 1'b1, 26'h0000077, 1'b1);
        compare("s4_rd_gnt",  32'(last_rgnt), 32'd1);
        compare("s4_rd_rdy",  32'(last_rrdy), 32'd1);
        compare("s4_rd_cmd",  32'(last_cmd),  32'd1);
        compare("s4_rd_addr", 32'(last_addr), 32'h0000077);

        // Scenario 5: asynchronous reset while a write is stalled.
        doReset();
        runCycle(1'b1, 26'h0000abc, 1'b0, '0, 1'b0);
        runCycle(1'b1, 26'h0000abc, 1'b0, '0, 1'b0);
        compare("s5_pre_app_en", 32'(last_en), 32'd1);
        applyStimulus(1'b1, 26'h0000abc, 1'b0, '0, 1'b0);
        midCycleReset("s5");
        runCycle(1'b0, '0, 1'b0, '0, 1'b1);
        compare("s5_idle_wr_gnt", 32'(last_wgnt), 32'd0);
        compare("s5_idle_rd_gnt", 32'(last_rgnt), 32'd0);

        // Randomized traffic in phases of differing request and ready density.
        doReset();
        for (int ph = 0; ph < 15; ph++) begin
            p_we  = $urandom_range(0, 100);
            p_re  = $urandom_range(0, 100);
            p_rdy = $urandom_range(10, 100);
            for (int c = 0; c < 200; c++) begin
                runCycle($urandom_range(0, 99) < p_we, 26'($urandom()),
                         $urandom_range(0, 99) < p_re, 26'($urandom()),
                         $urandom_range(0, 99) < p_rdy);
                if ($urandom_range(0, 399) == 0) begin
                    applyStimulus(1'b1, 26'($urandom()), 1'b1, 26'($urandom()), 1'b0);
                    midCycleReset("rnd_reset");
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
